mem_port_arbiter: RTL

Arbiter and sequencer that shares one single-port unified instruction/data memory between the pipelined CPU's IF stage and MEM stage. It grants one access at a time and drives the memory's enable/address/data pins. It returns read data to the winning stage with a one-cycle ready pulse and raises a pipeline stall while any request is outstanding. MEM has priority, with a starvation guard that forces an IF grant after a bounded run of MEM grants.

---
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port unified memory between the IF and
// MEM pipeline stages. MEM has priority. A starvation counter forces an IF
// grant after STARVE_MAX back-to-back MEM grants taken while IF was waiting.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    // IF stage port (read only)
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ready_o,
    output logic [DATA_W-1:0] if_rdata_o,
    // MEM stage port
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic              mem_ready_o,
    output logic [DATA_W-1:0] mem_rdata_o,
    // Memory pins
    output logic              m_en_o,
    output logic              m_we_o,
    output logic [ADDR_W-1:0] m_addr_o,
    output logic [DATA_W-1:0] m_wdata_o,
    input  logic [DATA_W-1:0] m_rdata_i,
    // Pipeline stall
    output logic              pipe_stall_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [1:0]        state_q,       state_d;
    logic              gnt_is_mem_q,  gnt_is_mem_d;
    logic              gnt_we_q,      gnt_we_d;
    logic [2:0]        lat_cnt_q,     lat_cnt_d;
    logic [3:0]        starve_cnt_q,  starve_cnt_d;
    logic              m_en_q,        m_en_d;
    logic              m_we_q,        m_we_d;
    logic [ADDR_W-1:0] m_addr_q,      m_addr_d;
    logic [DATA_W-1:0] m_wdata_q,     m_wdata_d;
    logic              if_ready_q,    if_ready_d;
    logic              mem_ready_q,   mem_ready_d;
    logic [DATA_W-1:0] if_rdata_q,    if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q,   mem_rdata_d;
    logic              grant_mem;

    // Arbitration, access sequencing and response capture.
    always_comb begin
        state_d      = state_q;
        gnt_is_mem_d = gnt_is_mem_q;
        gnt_we_d     = gnt_we_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;
        m_en_d       = 1'b0;
        m_we_d       = 1'b0;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        if_ready_d   = 1'b0;
        mem_ready_d  = 1'b0;
        if_rdata_d   = if_rdata_q;
        mem_rdata_d  = mem_rdata_q;
        grant_mem    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mem_req_i || if_req_i) begin
                    grant_mem    = mem_req_i && !(if_req_i && (starve_cnt_q == STARVE_LIM));
                    gnt_is_mem_d = grant_mem;
                    gnt_we_d     = grant_mem && mem_we_i;
                    m_addr_d     = grant_mem ? mem_addr_i : if_addr_i;
                    m_wdata_d    = mem_wdata_i;
                    m_we_d       = grant_mem && mem_we_i;
                    m_en_d       = 1'b1;
                    lat_cnt_d    = LAT_INIT;
                    if (grant_mem && if_req_i) begin
                        starve_cnt_d = (starve_cnt_q == STARVE_LIM) ? STARVE_LIM
                                                                   : 4'(starve_cnt_q + 4'd1);
                    end else begin
                        starve_cnt_d = '0;
                    end
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // The m_en cycle is the address phase; latency counting starts
                // after the memory has captured, so ready lands MEM_LAT+1 edges
                // after the grant.
                if (!m_en_q) begin
                    if (lat_cnt_q == 3'd1) begin
                        lat_cnt_d = '0;
                        if (gnt_is_mem_q) begin
                            mem_ready_d = 1'b1;
                            if (!gnt_we_q) begin
                                mem_rdata_d = m_rdata_i;
                            end
                        end else begin
                            if_ready_d = 1'b1;
                            if_rdata_d = m_rdata_i;
                        end
                        state_d = S_RESP;
                    end else begin
                        lat_cnt_d = lat_cnt_q - 3'd1;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            gnt_is_mem_q <= 1'b0;
            gnt_we_q     <= 1'b0;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
            m_en_q       <= 1'b0;
            m_we_q       <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            if_ready_q   <= 1'b0;
            mem_ready_q  <= 1'b0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            gnt_is_mem_q <= gnt_is_mem_d;
            gnt_we_q     <= gnt_we_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            m_en_q       <= m_en_d;
            m_we_q       <= m_we_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            if_ready_q   <= if_ready_d;
            mem_ready_q  <= mem_ready_d;
            if_rdata_q   <= if_rdata_d;
            mem_rdata_q  <= mem_rdata_d;
        end
    end

    // Output mapping; stall is combinational from the live requests.
    always_comb begin
        m_en_o       = m_en_q;
        m_we_o       = m_we_q;
        m_addr_o     = m_addr_q;
        m_wdata_o    = m_wdata_q;
        if_ready_o   = if_ready_q;
        if_rdata_o   = if_rdata_q;
        mem_ready_o  = mem_ready_q;
        mem_rdata_o  = mem_rdata_q;
        pipe_stall_o = (if_req_i & ~if_ready_q) | (mem_req_i & ~mem_ready_q);
    end

endmodule
